gba_line_cache: RTL

- Sits directly upstream of the HDMI image generator.
- Stores the most recent GBA video lines, already converted to RGB888, in four line banks.
- Presents a 3x3 pixel neighbourhood (previous/current/next line × previous/current/next pixel) around the pixel index the image generator requests.
- Paces line advance with a sameLine/nextLine handshake and signals frame start to the consumer via newFrameOut.

---
 rtl/gba_line_cache_if.sv | 44 ++++
 rtl/gba_line_cache.sv | 106 ++++++++++
 2 files changed

// File: rtl/gba_line_cache_if.sv
// gba_line_cache_if: capture-side write bus, consumer handshake and 3x3 RGB888 neighbourhood
// presented by gba_line_cache.
interface gba_line_cache_if;
   logic       wrFrameStart, wrEn, wrLineDone, nextLine, cacheUpdate;
   logic [7:0] wrAddr, wrRed, wrGreen, wrBlue, curPxl;
   logic [7:0] prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut;
   logic [7:0] prevLineCurPxlRedOut, prevLineCurPxlGreenOut, prevLineCurPxlBlueOut;
   logic [7:0] prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut;
   logic [7:0] curLinePrevPxlRedOut, curLinePrevPxlGreenOut, curLinePrevPxlBlueOut;
   logic [7:0] curLineCurPxlRedOut, curLineCurPxlGreenOut, curLineCurPxlBlueOut;
   logic [7:0] curLineNextPxlRedOut, curLineNextPxlGreenOut, curLineNextPxlBlueOut;
   logic [7:0] nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut;
   logic [7:0] nextLineCurPxlRedOut, nextLineCurPxlGreenOut, nextLineCurPxlBlueOut;
   logic [7:0] nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut;
   logic       sameLine, newFrameOut, overflow;
   modport master (
      output wrFrameStart, wrEn, wrLineDone, nextLine, cacheUpdate,
             wrAddr, wrRed, wrGreen, wrBlue, curPxl,
      input  prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
             prevLineCurPxlRedOut, prevLineCurPxlGreenOut, prevLineCurPxlBlueOut,
             prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
             curLinePrevPxlRedOut, curLinePrevPxlGreenOut, curLinePrevPxlBlueOut,
             curLineCurPxlRedOut, curLineCurPxlGreenOut, curLineCurPxlBlueOut,
             curLineNextPxlRedOut, curLineNextPxlGreenOut, curLineNextPxlBlueOut,
             nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
             nextLineCurPxlRedOut, nextLineCurPxlGreenOut, nextLineCurPxlBlueOut,
             nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut,
             sameLine, newFrameOut, overflow
   );
   modport slave (
      input  wrFrameStart, wrEn, wrLineDone, nextLine, cacheUpdate,
             wrAddr, wrRed, wrGreen, wrBlue, curPxl,
      output prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
             prevLineCurPxlRedOut, prevLineCurPxlGreenOut, prevLineCurPxlBlueOut,
             prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
             curLinePrevPxlRedOut, curLinePrevPxlGreenOut, curLinePrevPxlBlueOut,
             curLineCurPxlRedOut, curLineCurPxlGreenOut, curLineCurPxlBlueOut,
             curLineNextPxlRedOut, curLineNextPxlGreenOut, curLineNextPxlBlueOut,
             nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
             nextLineCurPxlRedOut, nextLineCurPxlGreenOut, nextLineCurPxlBlueOut,
             nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut,
             sameLine, newFrameOut, overflow
   );
endinterface

// File: rtl/gba_line_cache.sv
// gba_line_cache: four-bank RGB888 line cache presenting a registered 3x3 neighbourhood to the HDMI generator.
// Define LINECACHE_BLANK_EDGE_EN to output black for neighbours outside the frame instead of replicating edges.
module gba_line_cache #(
   parameter int LINE_PXLS   = 240,
   parameter int FRAME_LINES = 160,
   parameter int NUM_BANKS   = 4
) (
   input logic             pxlClk,
   input logic             rst,
   gba_line_cache_if.slave bus
);
   localparam logic [7:0] LAST_PXL  = 8'(LINE_PXLS - 1);
   localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);
   localparam logic [7:0] NLINES    = 8'(FRAME_LINES);

   logic [23:0] mem [NUM_BANKS][LINE_PXLS];
   logic [7:0]  wr_line_q, wr_line_d, wr_done_q, wr_done_d, rd_line_q, rd_line_d;
   logic        same_line_q, same_line_d, new_frame_q, new_frame_d, overflow_q, overflow_d;
   logic        top_edge_q, top_edge_d, bot_edge_q, bot_edge_d;
   logic [23:0] pix_q [3][3];
   logic [23:0] pix_d [3][3];
   logic        adv, handoff;
   logic [7:0]  wr_inc, c;
   logic [7:0]  col [3];
   logic [1:0]  wr_bank;
   logic [1:0]  row_bank [3];

   always_comb begin
      wr_inc      = (wr_line_q == NLINES) ? NLINES : wr_line_q + 8'd1;
      wr_bank     = bus.wrFrameStart ? 2'd0 : wr_line_q[1:0];
      adv         = bus.nextLine && bus.cacheUpdate && !same_line_q;
      wr_line_d   = bus.wrFrameStart ? 8'd0 : bus.wrLineDone ? wr_inc : wr_line_q;
      wr_done_d   = bus.wrFrameStart ? 8'd0 : bus.wrLineDone ? wr_inc : wr_done_q;
      handoff     = (wr_done_d == 8'd2) && (wr_done_q != 8'd2);
      rd_line_d   = handoff ? 8'd0 : adv ? rd_line_q + 8'd1 : rd_line_q;
      new_frame_d = handoff || (new_frame_q && !adv);
      // the writer stepping into the bank still shown as the prev row corrupts it
      overflow_d  = overflow_q || (bus.wrLineDone && !bus.wrFrameStart && !new_frame_q &&
                    (wr_line_q + 8'd1 == rd_line_q + 8'd3));
      top_edge_d  = (bus.cacheUpdate || handoff) ? (rd_line_d == 8'd0) : top_edge_q;
      bot_edge_d  = (bus.cacheUpdate || handoff) ? (rd_line_d == LAST_LINE) : bot_edge_q;
      same_line_d = !((rd_line_d + 8'd1 < NLINES) && ((rd_line_d + 8'd2 < wr_done_d) ||
                    ((rd_line_d + 8'd2 == NLINES) && (rd_line_d + 8'd1 < wr_done_d))));
      c           = (bus.curPxl > LAST_PXL) ? LAST_PXL : bus.curPxl;
      col[0]      = (c == 8'd0) ? 8'd0 : c - 8'd1;
      col[1]      = c;
      col[2]      = (c == LAST_PXL) ? LAST_PXL : c + 8'd1;
      row_bank[1] = rd_line_q[1:0];
      row_bank[0] = top_edge_q ? row_bank[1] : row_bank[1] - 2'd1;
      row_bank[2] = bot_edge_q ? row_bank[1] : row_bank[1] + 2'd1;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            pix_d[r][k] = mem[row_bank[r]][col[k]];
`ifdef LINECACHE_BLANK_EDGE_EN
      for (int k = 0; k < 3; k++) begin
         if (top_edge_q) pix_d[0][k] = 24'd0;
         if (bot_edge_q) pix_d[2][k] = 24'd0;
      end
      for (int r = 0; r < 3; r++) begin
         if (c == 8'd0) pix_d[r][0] = 24'd0;
         if (c == LAST_PXL) pix_d[r][2] = 24'd0;
      end
`endif
   end

   always_ff @(posedge pxlClk)
      if (bus.wrEn && bus.wrAddr <= LAST_PXL)
         mem[wr_bank][bus.wrAddr] <= {bus.wrRed, bus.wrGreen, bus.wrBlue};

   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst) begin
         wr_line_q   <= 8'd0;
         wr_done_q   <= 8'd0;
         rd_line_q   <= 8'd0;
         same_line_q <= 1'b1;
         new_frame_q <= 1'b0;
         overflow_q  <= 1'b0;
         top_edge_q  <= 1'b0;
         bot_edge_q  <= 1'b0;
         pix_q       <= '{default: '0};
      end else begin
         wr_line_q   <= wr_line_d;
         wr_done_q   <= wr_done_d;
         rd_line_q   <= rd_line_d;
         same_line_q <= same_line_d;
         new_frame_q <= new_frame_d;
         overflow_q  <= overflow_d;
         top_edge_q  <= top_edge_d;
         bot_edge_q  <= bot_edge_d;
         pix_q       <= pix_d;
      end
   end

   assign {bus.prevLinePrevPxlRedOut, bus.prevLinePrevPxlGreenOut, bus.prevLinePrevPxlBlueOut} = pix_q[0][0];
   assign {bus.prevLineCurPxlRedOut,  bus.prevLineCurPxlGreenOut,  bus.prevLineCurPxlBlueOut}  = pix_q[0][1];
   assign {bus.prevLineNextPxlRedOut, bus.prevLineNextPxlGreenOut, bus.prevLineNextPxlBlueOut} = pix_q[0][2];
   assign {bus.curLinePrevPxlRedOut,  bus.curLinePrevPxlGreenOut,  bus.curLinePrevPxlBlueOut}  = pix_q[1][0];
   assign {bus.curLineCurPxlRedOut,   bus.curLineCurPxlGreenOut,   bus.curLineCurPxlBlueOut}   = pix_q[1][1];
   assign {bus.curLineNextPxlRedOut,  bus.curLineNextPxlGreenOut,  bus.curLineNextPxlBlueOut}  = pix_q[1][2];
   assign {bus.nextLinePrevPxlRedOut, bus.nextLinePrevPxlGreenOut, bus.nextLinePrevPxlBlueOut} = pix_q[2][0];
   assign {bus.nextLineCurPxlRedOut,  bus.nextLineCurPxlGreenOut,  bus.nextLineCurPxlBlueOut}  = pix_q[2][1];
   assign {bus.nextLineNextPxlRedOut, bus.nextLineNextPxlGreenOut, bus.nextLineNextPxlBlueOut} = pix_q[2][2];
   assign bus.sameLine    = same_line_q;
   assign bus.newFrameOut = new_frame_q;
   assign bus.overflow    = overflow_q;
endmodule
